axis_fetch_pc_gen: RTL and testbench
====================================

// Module: axis_fetch_pc_gen
// PURPOSE
//  Sequential fetch-address generator that feeds the fetch-request AXI-Stream FIFO (axis_sync_fifo).
//  Emits one XLEN-bit word-aligned PC per beat on its manager port. Steps by 4 on every accepted beat.
//  On a redirect it pulses invalidate to flush the downstream FIFO, then resumes from the new PC.
//  Supports a halt request that parks issue until the next redirect.
// PARAMETERS
//  XLEN      32            PC / tdata width
//  RESET_PC  32'h8000_0000 first PC issued after reset; bits [1:0] must be 0
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  rst_n          in   1     asynchronous active-low reset
//  redirect_valid in   1     one-cycle request to restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch PC; bits [1:0] ignored (forced to 0)
//  halt_req       in   1     level; stop issuing after the current beat completes
//  halted         out  1     1 while in HALT
//  mif_tvalid     out  1     AXIS valid toward the FIFO
//  mif_tdata      out  XLEN  AXIS data = current PC
//  mif_tready     in   1     AXIS ready from the FIFO
//  invalidate     out  1     one-cycle flush pulse to the FIFO invalidate input
// BEHAVIOUR
//  Reset (async assert, sync release):
//   state=BOOT, pc=RESET_PC, mif_tvalid=0, invalidate=0, halted=0.
//  Outputs are registered or state-decoded only, with no combinational path from inputs to outputs:
//   mif_tvalid=(state==RUN), mif_tdata=pc, halted=(state==HALT), invalidate=(state==FLUSH).
//  Handshake: a beat transfers when mif_tvalid & mif_tready.
//   On a transfer, pc <= pc + 4, truncated to XLEN bits (wraps 'hFFFF_FFFC -> 0).
//  AXIS hold rule: in RUN, mif_tvalid and mif_tdata stay stable until the beat transfers.
//   The only exception is a redirect; the following invalidate pulse discards the pending beat.
//  States and transitions (priority top-down within a cycle):
//   any state, redirect_valid=1 -> FLUSH; pc <= {redirect_pc[XLEN-1:2],2'b00}.
//     A beat handshaking in the same cycle still transfers but is flushed by the pulse; pc does not +4.
//   BOOT  -> RUN after exactly one cycle; halt_req is ignored in BOOT.
//   FLUSH -> RUN after one cycle; invalidate=1 and mif_tvalid=0 during FLUSH; pc held.
//   RUN, halt_req=1 & transfer this cycle    -> HALT (pc += 4).
//   RUN, halt_req=1 & no transfer             -> stay RUN (hold beat; halt pending until transfer).
//   RUN, halt_req=0                           -> stay RUN.
//   HALT  -> stays HALT regardless of halt_req; exits only via redirect (-> FLUSH).
//  Latency: redirect seen at edge N -> invalidate high in cycle N+1 -> first new-PC beat valid in cycle N+2.
//  Back-to-back redirects: each restarts FLUSH. The latest redirect_pc wins. Invalidate stays high continuously.
//  Redirect during BOOT: the PC is overridden, FLUSH runs, and RESET_PC is never issued.
//  Reset mid-operation: everything returns to reset values asynchronously.
//   No invalidate pulse is generated; the FIFO is reset by the same rst_n.
//  Throughput: one beat per cycle while mif_tready=1 in RUN.
// TESTING
//  1 Reset, tready=1 for 4 cycles -> tvalid low for 1 cycle, then beats 8000_0000, 8000_0004, 8000_0008.
//  2 tready=0 for 3 cycles mid-stream -> tdata held at same PC with tvalid=1; resumes +4 after tready=1.
//  3 redirect_valid with redirect_pc=0000_1237 while beat 8000_0010 pending ->
//    next cycle invalidate=1, tvalid=0; following cycle tdata=0000_1234.
//  4 halt_req=1 with tready=0 -> stays RUN until transfer; then halted=1, tvalid=0;
//    redirect to 0000_0100 -> FLUSH, then beats restart at 0000_0100.
//  5 redirect to FFFF_FFFC, tready=1 -> beats FFFF_FFFC, then 0000_0000 (wrap).
//  6 rst_n dropped mid-stream, redirect in cycle after release, plus redirects on 2 consecutive cycles ->
//    async clear; invalidate high 2 cycles; first beat = second redirect_pc.
//  Checkers: tvalid never falls without a transfer except in a FLUSH cycle; tdata[1:0]==0 always.

Source files
------------

// File: rtl/axis_fetch_pc_gen.sv
// axis_fetch_pc_gen: sequential fetch-PC generator driving an AXI-Stream manager port,
// with redirect-triggered downstream flush and a halt that parks issue until the next redirect.
module axis_fetch_pc_gen #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            halted,
    output logic            mif_tvalid,
    output logic [XLEN-1:0] mif_tdata,
    input  logic            mif_tready,
    output logic            invalidate
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            xfer;

    assign xfer       = (state_q == RUN) & mif_tready;
    assign mif_tvalid = (state_q == RUN);
    assign mif_tdata  = pc_q;
    assign halted     = (state_q == HALT);
    assign invalidate = (state_q == FLUSH);

    // A redirect overrides everything; a beat handshaking in that cycle is dropped by the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            state_q <= FLUSH;
            pc_q    <= {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            case (state_q)
                BOOT, FLUSH: state_q <= RUN;
                RUN: begin
                    if (xfer) pc_q <= pc_q + XLEN'(4);
                    if (xfer && halt_req) state_q <= HALT;
                end
                default: state_q <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_fetch_pc_gen.sv
// tb_axis_fetch_pc_gen: directed vectors with hand-computed PCs, plus an AXIS hold
// and alignment check on every stepped cycle.
module tb_axis_fetch_pc_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        mif_tvalid;
    logic [31:0] mif_tdata;
    logic        mif_tready = 1'b0;
    logic        invalidate;

    int n_chk = 0;
    int n_pass = 0;
    logic        prev_valid = 1'b0;
    logic        prev_xfer = 1'b0;
    logic [31:0] prev_data = '0;

    axis_fetch_pc_gen dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halted(halted), .mif_tvalid(mif_tvalid), .mif_tdata(mif_tdata),
        .mif_tready(mif_tready), .invalidate(invalidate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic inv, input logic h);
        chk({tag, ".tvalid"}, 32'(mif_tvalid), 32'(v));
        chk({tag, ".tdata"}, mif_tdata, d);
        chk({tag, ".invalidate"}, 32'(invalidate), 32'(inv));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        prev_valid = mif_tvalid;
        prev_xfer  = mif_tvalid & mif_tready;
        prev_data  = mif_tdata;
        @(posedge clk);
        #1;
        chk("align", 32'(mif_tdata[1:0]), 32'd0);
        if (rst_n && prev_valid && !prev_xfer && !invalidate)
            chk("hold", {mif_tvalid, mif_tdata[30:0]}, {1'b1, prev_data[30:0]});
    endtask

    initial begin
        repeat (2) step();
        rst_n = 1'b1;
        expect_out("reset", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

        // 1: boot then back-to-back beats
        mif_tready = 1'b1;
        step(); expect_out("boot0", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        step(); expect_out("beat1", 1'b1, 32'h8000_0004, 1'b0, 1'b0);
        step(); expect_out("beat2", 1'b1, 32'h8000_0008, 1'b0, 1'b0);
        step(); expect_out("beat3", 1'b1, 32'h8000_000C, 1'b0, 1'b0);

        // 2: backpressure holds the beat
        mif_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("stall", 1'b1, 32'h8000_000C, 1'b0, 1'b0);
        end
        mif_tready = 1'b1;
        step(); expect_out("resume", 1'b1, 32'h8000_0010, 1'b0, 1'b0);
        mif_tready = 1'b0;

        // 3: redirect with pending beat, low bits forced to zero
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1237;
        step(); expect_out("flush3", 1'b0, 32'h0000_1234, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_out("redir3", 1'b1, 32'h0000_1234, 1'b0, 1'b0);

        // 4: halt waits for the transfer, then parks until redirect
        halt_req = 1'b1;
        step(); expect_out("halt_pend0", 1'b1, 32'h0000_1234, 1'b0, 1'b0);
        step(); expect_out("halt_pend1", 1'b1, 32'h0000_1234, 1'b0, 1'b0);
        mif_tready = 1'b1;
        step(); expect_out("halted", 1'b0, 32'h0000_1238, 1'b0, 1'b1);
        halt_req = 1'b0;
        step(); expect_out("halt_stay", 1'b0, 32'h0000_1238, 1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step(); expect_out("flush4", 1'b0, 32'h0000_0100, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_out("redir4a", 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        step(); expect_out("redir4b", 1'b1, 32'h0000_0104, 1'b0, 1'b0);

        // 5: wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); expect_out("flush5", 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_out("top", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(); expect_out("wrap", 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        step(); expect_out("wrap1", 1'b1, 32'h0000_0004, 1'b0, 1'b0);

        // 6: async reset mid-stream, then redirects on two consecutive cycles
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        step(); expect_out("in_rst", 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        step(); expect_out("b2b0", 1'b0, 32'h0000_2000, 1'b1, 1'b0);
        redirect_pc = 32'h0000_3002;
        step(); expect_out("b2b1", 1'b0, 32'h0000_3000, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_out("b2b_beat0", 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        step(); expect_out("b2b_beat1", 1'b1, 32'h0000_3004, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
